// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
// Both the receiver and the transmitter use this package.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                              input int unsigned baudrate);
    return bit_cycles(clk_freq, baudrate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The flops reset to RESET_VALUE so an idle-high line does not look like an edge.
module sync_2ff #(
  parameter bit RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      dout <= RESET_VALUE;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, BITLEN data bits MSB first, 1 stop bit, no parity.
// Start bit is confirmed at mid-bit, data and stop bits sampled one bit period apart.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = 115200,
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BITLEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BITLEN-1:0] data,
  output logic              data_valid,
  output logic              frame_error,
  output logic              busy
);

  localparam int unsigned BITCYCLE  = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int unsigned HALFCYCLE = half_cycles(CLK_FREQ, BAUDRATE);
  localparam int unsigned CNT_W     = $clog2(BITCYCLE);
  localparam int unsigned IDX_W     = $clog2(BITLEN) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BITCYCLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALFCYCLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BITLEN - 1);

  logic              rx_sync;
  uart_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [BITLEN-1:0] shift;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx),
    .dout (rx_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        StIdle: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_sync) begin
            state <= StStart;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_sync) begin
              state <= StData;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= (shift << 1) | BITLEN'(rx_sync);
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= StStop;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= StIdle;
            busy  <= 1'b0;
            if (rx_sync) begin
              data       <= shift;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 100 MHz / 115200 baud (868 cycles per bit).
module tb_uart_rx;

  localparam int unsigned BIT_N  = 868;
  localparam int unsigned BIT_HI = 885;  // +2% period
  localparam int unsigned BIT_LO = 851;  // -2% period

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] words[$];

  uart_rx #(
    .BAUDRATE (115200),
    .CLK_FREQ (100_000_000),
    .BITLEN   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses are counted per cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (data_valid || frame_error) check("flags_exclusive", {31'd0, data_valid & frame_error}, 0);
    if (data_valid) begin
      dv_cnt++;
      words.push_back(data);
    end
    if (frame_error) fe_cnt++;
  end

  task automatic send_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned n, input logic stop);
    send_bit(1'b0, n);
    for (int i = 7; i >= 0; i--) send_bit(d[i], n);
    send_bit(stop, n);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data}, 0);
    check("reset_dv", {31'd0, data_valid}, 0);
    check("reset_fe", {31'd0, frame_error}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame
    send_frame(8'hA5, BIT_N, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_dv_count", dv_cnt, 1);
    check("a5_fe_count", fe_cnt, 0);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_busy_idle", {31'd0, busy}, 0);

    // Back-to-back frames, no idle gap between stop and next start
    send_frame(8'h00, BIT_N, 1'b1);
    send_frame(8'hFF, BIT_N, 1'b1);
    send_frame(8'h3C, BIT_N, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_dv_count", dv_cnt, 4);
    check("b2b_word0", {24'd0, words[1]}, 32'h00);
    check("b2b_word1", {24'd0, words[2]}, 32'hFF);
    check("b2b_word2", {24'd0, words[3]}, 32'h3C);

    // Stop bit held low
    send_frame(8'h5A, BIT_N, 1'b0);
    repeat (20) @(negedge clk);
    check("badstop_fe_count", fe_cnt, 1);
    check("badstop_dv_count", dv_cnt, 4);
    check("badstop_data_hold", {24'd0, data}, 32'h3C);

    // Short low pulse is a false start
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 1);
    repeat (190) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 0);
    check("glitch_dv_count", dv_cnt, 4);
    check("glitch_fe_count", fe_cnt, 1);

    // Baud skew
    send_frame(8'h96, BIT_HI, 1'b1);
    repeat (20) @(negedge clk);
    check("skew_slow_data", {24'd0, data}, 32'h96);
    check("skew_slow_dv", dv_cnt, 5);
    send_frame(8'h69, BIT_LO, 1'b1);
    repeat (20) @(negedge clk);
    check("skew_fast_data", {24'd0, data}, 32'h69);
    check("skew_fast_dv", dv_cnt, 6);
    check("skew_fe_count", fe_cnt, 1);

    // Reset during bit 4 of 0xC3 (MSB-first bits 1,1,0,0,0,...)
    send_bit(1'b0, BIT_N);
    send_bit(1'b1, BIT_N);
    send_bit(1'b1, BIT_N);
    send_bit(1'b0, BIT_N);
    send_bit(1'b0, BIT_N);
    rx = 1'b0;
    repeat (300) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_data", {24'd0, data}, 0);
    check("rst_async_busy", {31'd0, busy}, 0);
    check("rst_async_dv", {31'd0, data_valid}, 0);
    check("rst_async_fe", {31'd0, frame_error}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 0);
    check("post_rst_no_pulse", dv_cnt + fe_cnt, 7);
    send_frame(8'h81, BIT_N, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_data", {24'd0, data}, 32'h81);
    check("post_rst_dv", dv_cnt, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUDRATE, default 115200: serial bit rate in bits/s.
REQ-002 Parameter CLK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-003 Parameter BITLEN, default 8: data bits per frame.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 data  output  BITLEN  last correctly framed received word.
REQ-008 data_valid  output  1  one-cycle pulse, data updated.
REQ-009 frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high while a frame is in reception.

Function
REQ-011 The block SHALL derive BITCYCLE = CLK_FREQ/BAUDRATE (integer division) and HALFCYCLE = BITCYCLE/2.
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value only (2-cycle input latency).
REQ-013 Frame format: 1 start bit (low), BITLEN data bits MSB first, 1 stop bit (high), no parity; this matches uart_tx bit order.
REQ-014 States: IDLE, START, DATA, STOP; busy SHALL be high in START, DATA and STOP, low in IDLE.
REQ-015 IDLE: counter and bit index held at 0; a synchronized low SHALL move to START on the next edge.
REQ-016 START: counter increments; at count == HALFCYCLE-1 sample rx; low -> clear counter, go DATA; high -> false start, go IDLE with no pulse.
REQ-017 DATA: counter increments; at count == BITCYCLE-1 shift sampled bit into LSB of shift register (left shift), clear counter, increment index.
REQ-018 DATA SHALL go to STOP once BITLEN bits are captured; index SHALL clear on that transition.
REQ-019 STOP: at count == BITCYCLE-1 sample rx; high -> data <= shift register and data_valid high for exactly one cycle; low -> frame_error high for exactly one cycle, data unchanged.
REQ-020 STOP SHALL return to IDLE on the same edge as the stop-bit sample, so a start edge arriving half a bit later is accepted (back-to-back frames).
REQ-021 data_valid and frame_error SHALL never be high in the same cycle.
REQ-022 data SHALL hold its value between data_valid pulses.
REQ-023 Counter width SHALL be $clog2(BITCYCLE); index width $clog2(BITLEN)+1 so BITLEN is representable.
REQ-024 Illegal state encoding SHALL return to IDLE on the next edge.
REQ-025 rx glitches shorter than HALFCYCLE SHALL be rejected as false starts.

Reset
REQ-026 On rst high, immediately and regardless of clk: state IDLE, counter 0, index 0, shift register 0, data 0, data_valid 0, frame_error 0, busy 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL restart only on a fresh falling edge.

Structure
REQ-028 State encodings and the BITCYCLE/HALFCYCLE computation SHALL live in a shared package uart_pkg, also used by uart_tx.
REQ-029 The 2-flop input synchronizer SHALL be a sub-module sync_2ff (reset value parameterized, here 1).
REQ-030 The remainder SHALL be one sequential FSM block in uart_rx; no FIFO inside.

Verification (CLK_FREQ 100e6, BAUDRATE 115200: BITCYCLE 868, HALFCYCLE 434)
REQ-031 Frame 0xA5 with valid stop -> one data_valid pulse, data = 0xA5, frame_error stays 0.
REQ-032 uart_tx instance looped to rx, words 0x00, 0xFF, 0x3C sent back-to-back -> three data_valid pulses with matching data in order.
REQ-033 Frame 0x5A with stop bit held low -> one frame_error pulse, no data_valid, data keeps previous value.
REQ-034 rx low for 200 cycles then high -> busy rises, returns to IDLE, no pulse on either flag.
REQ-035 rst asserted during bit 4 of frame 0xC3 -> all outputs 0 same cycle; next clean frame 0x81 -> data = 0x81.
REQ-036 Baud skew: frame 0x96 sent at +/-2% bit period -> data = 0x96, no frame_error.
